// File: rtl/flappy_pkg.sv
// ============================================================================
// flappy_pkg : shared states, renderer geometry and LFSR seed for the game core
// Rev 1.0
// ============================================================================
`default_nettype none

package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2
    } state_t;

    // Renderer line/column geometry; only the left pipe can reach the bird column.
    localparam logic [10:0] c_bird_col_lo = 11'd101;
    localparam logic [10:0] c_bird_col_hi = 11'd139;
    localparam logic [10:0] c_gap_top_ofs = 11'd75;
    localparam logic [10:0] c_gap_bot_ofs = 11'd215;
    localparam logic [8:0]  c_win_lo      = 9'd157;
    localparam logic [8:0]  c_win_hi      = 9'd243;
    localparam logic [8:0]  c_score_line  = 9'd244;
    localparam logic [10:0] c_top_line    = 11'd461;
    localparam logic [10:0] c_bot_line    = 11'd499;

    localparam logic [7:0]  c_lfsr_seed   = 8'hA5;
    localparam logic [7:0]  c_gap_reset   = 8'd100;
    localparam logic [7:0]  c_gap_max     = 8'd200;
    localparam logic [7:0]  c_gap_fold    = 8'd56;
    localparam logic [3:0]  c_score_max   = 4'd15;

    function automatic logic [7:0] gap_clamp(input logic [7:0] raw);
        return (raw <= c_gap_max) ? raw : (raw - c_gap_fold);
    endfunction

endpackage

`default_nettype wire

// File: rtl/flappy_game_ctrl_if.sv
// ============================================================================
// flappy_game_ctrl_if : frame inputs and per-frame game outputs to the renderer
// Rev 1.0
// ============================================================================
`default_nettype none

interface flappy_game_ctrl_if;
    logic       vsync;
    logic       btn_flap;
    logic [9:0] bird_coord;
    logic [8:0] pipe_pos;
    logic [7:0] pipe_array0;
    logic [7:0] pipe_array1;
    logic [3:0] current_score;
    logic       game_over;

    modport master (
        input  vsync, btn_flap,
        output bird_coord, pipe_pos, pipe_array0, pipe_array1, current_score, game_over
    );

    modport slave (
        output vsync, btn_flap,
        input  bird_coord, pipe_pos, pipe_array0, pipe_array1, current_score, game_over
    );
endinterface

`default_nettype wire

// File: rtl/flappy_lfsr.sv
// ============================================================================
// flappy_lfsr : free-running 8-bit LFSR (x^8+x^6+x^5+x^4+1) with gap clamp
// Rev 1.0
// ============================================================================
`default_nettype none

module flappy_lfsr
    import flappy_pkg::*;
(
    input  wire logic       dclk,
    input  wire logic       clr_n,
    output logic [7:0]      gap
);

    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // The all-zero lock-up state is unreachable from the seed; reseed defensively anyway.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            r_lfsr <= c_lfsr_seed;
        end else if (r_lfsr == 8'h00) begin
            r_lfsr <= c_lfsr_seed;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end
    end

    assign gap = gap_clamp(r_lfsr);

endmodule

`default_nettype wire

// File: rtl/flappy_game_ctrl.sv
// ============================================================================
// flappy_game_ctrl : per-frame game logic (FSM, physics, pipes, score) for VGA
// Optional build macro FLAPPY_GODMODE_EN: no pipe deaths, ground clamps.  Rev 1.0
// ============================================================================
`default_nettype none

module flappy_game_ctrl
    import flappy_pkg::*;
#(
    parameter int START_Y     = 240,
    parameter int BIRD_MIN    = 20,
    parameter int BIRD_MAX    = 460,
    parameter int FLAP_VEL    = 8,
    parameter int GRAVITY     = 1,
    parameter int MAX_FALL    = 10,
    parameter int SCROLL_STEP = 2,
    parameter int PIPE_PERIOD = 345,
    parameter int DEAD_FRAMES = 60
) (
    input  wire logic          dclk,
    input  wire logic          clr_n,
    flappy_game_ctrl_if.master gif
);

    localparam int                 c_cnt_w       = $clog2(DEAD_FRAMES + 1);
    localparam logic [9:0]         c_start_y     = 10'(START_Y);
    localparam logic signed [10:0] c_bird_min    = 11'(BIRD_MIN);
    localparam logic signed [10:0] c_bird_max    = 11'(BIRD_MAX);
    localparam logic signed [6:0]  c_flap_vel    = 7'(FLAP_VEL);
    localparam logic signed [6:0]  c_gravity     = 7'(GRAVITY);
    localparam logic signed [6:0]  c_fall_floor  = -7'(MAX_FALL);
    localparam logic [9:0]         c_scroll      = 10'(SCROLL_STEP);
    localparam logic [9:0]         c_period      = 10'(PIPE_PERIOD);
    localparam logic [c_cnt_w-1:0] c_dead_frames = c_cnt_w'(DEAD_FRAMES);

    state_t              r_state, w_state_next;
    logic [9:0]          r_bird, w_bird_next;
    logic signed [5:0]   r_vel, w_vel_next;
    logic [8:0]          r_pipe, w_pipe_next;
    logic [7:0]          r_arr0, w_arr0_next;
    logic [7:0]          r_arr1, w_arr1_next;
    logic [3:0]          r_score, w_score_next;
    logic                r_game_over, w_game_over_next;
    logic [c_cnt_w-1:0]  r_dead_cnt, w_dead_cnt_next;

    logic r_btn_s1, r_btn_s2, r_btn_q;
    logic r_vs_q, r_vs_qq;
    logic r_flap_pend;
    logic w_btn_rise, w_tick;
    logic [7:0] w_gap_new;

    flappy_lfsr u_lfsr (
        .dclk  (dclk),
        .clr_n (clr_n),
        .gap   (w_gap_new)
    );

    assign w_btn_rise = r_btn_s2 & ~r_btn_q;
    assign w_tick     = r_vs_q & ~r_vs_qq;

    // vsync history resets high so a release with vsync high is not seen as an edge.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            r_btn_s1    <= 1'b0;
            r_btn_s2    <= 1'b0;
            r_btn_q     <= 1'b0;
            r_vs_q      <= 1'b1;
            r_vs_qq     <= 1'b1;
            r_flap_pend <= 1'b0;
        end else begin
            r_btn_s1 <= gif.btn_flap;
            r_btn_s2 <= r_btn_s1;
            r_btn_q  <= r_btn_s2;
            r_vs_q   <= gif.vsync;
            r_vs_qq  <= r_vs_q;
            if (w_tick) begin
                r_flap_pend <= w_btn_rise;
            end else if (w_btn_rise) begin
                r_flap_pend <= 1'b1;
            end
        end
    end

    // One frame of flight physics and scrolling, evaluated from the current registers.
    logic signed [6:0]  w_vel_dec, w_vel_step;
    logic signed [10:0] w_h;
    logic [9:0]         w_p, w_bird_step;
    logic [8:0]         w_pipe_step;
    logic [7:0]         w_arr1_step;
    logic [10:0]        w_bird_top, w_bird_bot, w_gap_top, w_gap_bot;
    logic               w_ground, w_ceil, w_wrap, w_scored, w_in_win, w_hit;

    always_comb begin : play_step
        w_vel_dec = {r_vel[5], r_vel} - c_gravity;
        if (r_flap_pend) begin
            w_vel_step = c_flap_vel;
        end else if (w_vel_dec < c_fall_floor) begin
            w_vel_step = c_fall_floor;
        end else begin
            w_vel_step = w_vel_dec;
        end

        w_h      = $signed({1'b0, r_bird}) + {{4{w_vel_step[6]}}, w_vel_step};
        w_ground = (w_h < c_bird_min);
        w_ceil   = (w_h > c_bird_max);
        if (w_ground) begin
            w_bird_step = c_bird_min[9:0];
        end else if (w_ceil) begin
            w_bird_step = c_bird_max[9:0];
        end else begin
            w_bird_step = w_h[9:0];
        end

        w_p         = {1'b0, r_pipe} + c_scroll;
        w_wrap      = (w_p >= c_period);
        w_pipe_step = w_wrap ? 9'(w_p - c_period) : w_p[8:0];
        w_arr1_step = w_wrap ? r_arr0 : r_arr1;
        w_scored    = (r_pipe < c_score_line) && (w_pipe_step >= c_score_line);

        w_bird_top = c_top_line - {1'b0, w_bird_step};
        w_bird_bot = c_bot_line - {1'b0, w_bird_step};
        w_gap_top  = {3'b000, w_arr1_step} + c_gap_top_ofs;
        w_gap_bot  = {3'b000, w_arr1_step} + c_gap_bot_ofs;
        w_in_win   = (w_pipe_step >= c_win_lo) && (w_pipe_step <= c_win_hi);
        w_hit      = w_in_win && ((w_bird_top < w_gap_top) || (w_bird_bot > w_gap_bot));
    end

    // The IDLE->PLAY tick is itself the first flight frame, with the flap applied.
    always_comb begin : fsm_next
        w_state_next     = r_state;
        w_bird_next      = r_bird;
        w_vel_next       = r_vel;
        w_pipe_next      = r_pipe;
        w_arr0_next      = r_arr0;
        w_arr1_next      = r_arr1;
        w_score_next     = r_score;
        w_game_over_next = r_game_over;
        w_dead_cnt_next  = r_dead_cnt;

        if (w_tick) begin
            case (r_state)
                IDLE, PLAY: begin
                    if ((r_state == PLAY) || r_flap_pend) begin
                        w_state_next = PLAY;
                        w_vel_next   = w_vel_step[5:0];
                        w_bird_next  = w_bird_step;
                        w_pipe_next  = w_pipe_step;
                        w_arr1_next  = w_arr1_step;
                        if (w_wrap) begin
                            w_arr0_next = w_gap_new;
                        end
                        if (w_scored && (r_score != c_score_max)) begin
                            w_score_next = r_score + 4'd1;
                        end
`ifdef FLAPPY_GODMODE_EN
                        if (w_ground) begin
                            w_vel_next = '0;
                        end
`else
                        if (w_ground || w_hit) begin
                            w_state_next     = DEAD;
                            w_game_over_next = 1'b1;
                            w_dead_cnt_next  = '0;
                        end
`endif
                    end
                end
                DEAD: begin
                    if (r_dead_cnt != c_dead_frames) begin
                        w_dead_cnt_next = r_dead_cnt + 1'b1;
                    end else if (r_flap_pend) begin
                        w_state_next     = IDLE;
                        w_bird_next      = c_start_y;
                        w_vel_next       = '0;
                        w_pipe_next      = '0;
                        w_arr0_next      = c_gap_reset;
                        w_arr1_next      = c_gap_reset;
                        w_score_next     = '0;
                        w_game_over_next = 1'b0;
                        w_dead_cnt_next  = '0;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            r_state     <= IDLE;
            r_bird      <= c_start_y;
            r_vel       <= '0;
            r_pipe      <= '0;
            r_arr0      <= c_gap_reset;
            r_arr1      <= c_gap_reset;
            r_score     <= '0;
            r_game_over <= 1'b0;
            r_dead_cnt  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_bird      <= w_bird_next;
            r_vel       <= w_vel_next;
            r_pipe      <= w_pipe_next;
            r_arr0      <= w_arr0_next;
            r_arr1      <= w_arr1_next;
            r_score     <= w_score_next;
            r_game_over <= w_game_over_next;
            r_dead_cnt  <= w_dead_cnt_next;
        end
    end

    assign gif.bird_coord    = r_bird;
    assign gif.pipe_pos      = r_pipe;
    assign gif.pipe_array0   = r_arr0;
    assign gif.pipe_array1   = r_arr1;
    assign gif.current_score = r_score;
    assign gif.game_over     = r_game_over;

endmodule

`default_nettype wire

// File: tb/tb_flappy_game_ctrl.sv
// ============================================================================
// tb_flappy_game_ctrl : directed frame-by-frame bench for flappy_game_ctrl
// Honours FLAPPY_GODMODE_EN when compiled with it.  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_flappy_game_ctrl;

    logic dclk  = 1'b0;
    logic clr_n = 1'b0;

    flappy_game_ctrl_if gif ();

    flappy_game_ctrl dut (
        .dclk  (dclk),
        .clr_n (clr_n),
        .gif   (gif)
    );

    always #20 dclk = ~dclk;

    int total = 0;
    int bad   = 0;

    // Heights over one 17-frame flap cycle starting from 240 (velocities 8 down to -8).
    int h_cycle [17] = '{248, 255, 261, 266, 270, 273, 275, 276, 276,
                         275, 273, 270, 266, 261, 255, 248, 240};

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One video frame; an optional button press lands well before the vsync rise.
    task automatic frame(input bit flap);
        if (flap) gif.btn_flap = 1'b1;
        repeat (3) @(negedge dclk);
        gif.btn_flap = 1'b0;
        repeat (4) @(negedge dclk);
        gif.vsync = 1'b0;
        repeat (6) @(negedge dclk);
        gif.vsync = 1'b1;
        repeat (5) @(negedge dclk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_bird"},  int'(gif.bird_coord), 240);
        check({tag, "_pipe"},  int'(gif.pipe_pos), 0);
        check({tag, "_arr0"},  int'(gif.pipe_array0), 100);
        check({tag, "_arr1"},  int'(gif.pipe_array1), 100);
        check({tag, "_score"}, int'(gif.current_score), 0);
        check({tag, "_over"},  int'(gif.game_over), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        gif.vsync    = 1'b1;
        gif.btn_flap = 1'b0;
        clr_n        = 1'b0;
        repeat (3) @(negedge dclk);
        check_reset_vals("rst");
        clr_n = 1'b1;
        @(negedge dclk);

        repeat (3) frame(1'b0);
        check_reset_vals("idle3");

        frame(1'b1);
        check("start_bird", int'(gif.bird_coord), 248);
        check("start_pipe", int'(gif.pipe_pos), 2);
        check("start_over", int'(gif.game_over), 0);
        repeat (8) frame(1'b0);
        check("apex_bird", int'(gif.bird_coord), 276);
        check("apex_pipe", int'(gif.pipe_pos), 18);

        // Free fall: 221 at frame 19, then -10 per frame at the velocity floor.
        repeat (30) frame(1'b0);
        check("fall39_bird", int'(gif.bird_coord), 21);
        check("fall39_over", int'(gif.game_over), 0);
        frame(1'b0);
        check("ground_bird", int'(gif.bird_coord), 20);
        check("ground_pipe", int'(gif.pipe_pos), 80);
`ifdef FLAPPY_GODMODE_EN
        check("ground_over", int'(gif.game_over), 0);
        clr_n = 1'b0;
        @(negedge dclk);
        clr_n = 1'b1;
        @(negedge dclk);
`else
        check("ground_over", int'(gif.game_over), 1);
        repeat (29) frame(1'b0);
        frame(1'b1);
        check("dead30_bird", int'(gif.bird_coord), 20);
        check("dead30_pipe", int'(gif.pipe_pos), 80);
        check("dead30_over", int'(gif.game_over), 1);
        repeat (29) frame(1'b0);
        frame(1'b1);
        check("dead60_over", int'(gif.game_over), 1);
        frame(1'b1);
        check_reset_vals("dead61");
`endif
        frame(1'b0);
        check("idle_hold_bird", int'(gif.bird_coord), 240);

        // Long flight in the 240..276 band, clearing the two reset-valued pipes.
        for (int k = 1; k <= 345; k++) begin
            frame(((k - 1) % 17) == 0);
            check($sformatf("fly%0d_bird", k), int'(gif.bird_coord), h_cycle[(k - 1) % 17]);
            check($sformatf("fly%0d_pipe", k), int'(gif.pipe_pos), (2 * k) % 345);
            if (k == 121) check("fly121_score", int'(gif.current_score), 0);
            if (k == 122) check("fly122_score", int'(gif.current_score), 1);
            if (k == 173) begin
                check("wrap_arr1", int'(gif.pipe_array1), 100);
                check("wrap_arr0_le200", int'(gif.pipe_array0 <= 8'd200), 1);
            end
            if (k == 294) check("fly294_score", int'(gif.current_score), 1);
            if (k == 295) begin
                check("fly295_score", int'(gif.current_score), 2);
                check("fly295_over", int'(gif.game_over), 0);
            end
        end

        // Asynchronous reset mid-game.
        @(negedge dclk);
        clr_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge dclk);
        clr_n = 1'b1;
        repeat (3) @(negedge dclk);
        check("post_rst_bird", int'(gif.bird_coord), 240);

        // Climb to the ceiling and fly into the window of the left pipe (gap 100).
        for (int k = 1; k <= 79; k++) begin
            frame(1'b1);
            if (k == 27) check("climb27_bird", int'(gif.bird_coord), 456);
            if (k == 28) check("ceil_bird", int'(gif.bird_coord), 460);
            if (k == 78) begin
                check("pre_win_pipe", int'(gif.pipe_pos), 156);
                check("pre_win_over", int'(gif.game_over), 0);
            end
        end
        check("win_pipe", int'(gif.pipe_pos), 158);
        check("win_bird", int'(gif.bird_coord), 460);
`ifdef FLAPPY_GODMODE_EN
        check("win_over", int'(gif.game_over), 0);
`else
        check("win_over", int'(gif.game_over), 1);
        frame(1'b0);
        check("frozen_pipe", int'(gif.pipe_pos), 158);
        check("frozen_bird", int'(gif.bird_coord), 460);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
